// File: rtl/shift_register_sipo_rx_if.sv
// Bus bundle for the serial-to-parallel receiver: serial side, holding-register
// handshake (data_valid/data_ready, transfer when both are 1 on a rising edge) and status.
interface shift_register_sipo_rx_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             serial_in;
  logic             serial_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             overrun;
  logic             resync;

  modport slave (
    input  serial_in, serial_valid, frame_start, data_ready,
    output data_out, data_valid, busy, bit_count, overrun, resync
  );

  modport master (
    output serial_in, serial_valid, frame_start, data_ready,
    input  data_out, data_valid, busy, bit_count, overrun, resync
  );
endinterface

// File: rtl/shift_register_sipo_rx.sv
// Serial-in/parallel-out receiver: frames on frame_start, assembles WIDTH bits and
// hands completed words to a one-deep holding register; busy exposes the FSM state.
module shift_register_sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  shift_register_sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic             r_resync;
  logic             w_resync_nxt;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_first;
  logic             w_done;

  // A new frame starts from a cleared register so stale bits never leak into the word.
  assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], bus.serial_in}
                               : {bus.serial_in, r_sreg[WIDTH-1:1]};
  assign w_first   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.serial_in}
                               : {bus.serial_in, {(WIDTH-1){1'b0}}};

  assign w_done = (r_state == SHIFT) && bus.serial_valid && !bus.frame_start &&
                  (r_count == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_count_nxt   = r_count;
    w_resync_nxt  = 1'b0;
    w_overrun_nxt = 1'b0;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;

    if (r_valid && bus.data_ready) begin
      w_valid_nxt = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (bus.serial_valid && bus.frame_start) begin
          w_sreg_nxt  = w_first;
          w_count_nxt = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.serial_valid && bus.frame_start) begin
          w_sreg_nxt   = w_first;
          w_count_nxt  = CW'(1);
          w_resync_nxt = 1'b1;
        end else if (w_done) begin
          w_sreg_nxt  = w_shifted;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
          if (!r_valid || bus.data_ready) begin
            w_data_nxt  = w_shifted;
            w_valid_nxt = 1'b1;
          end else begin
            w_overrun_nxt = 1'b1;
          end
        end else if (bus.serial_valid) begin
          w_sreg_nxt  = w_shifted;
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg    <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_resync  <= 1'b0;
    end else begin
      r_sreg    <= w_sreg_nxt;
      r_count   <= w_count_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
      r_resync  <= w_resync_nxt;
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = (r_state == SHIFT);
  assign bus.bit_count  = r_count;
  assign bus.overrun    = r_overrun;
  assign bus.resync     = r_resync;
endmodule
